// File: rtl/cd_cfg_pkg.sv
// Shared types and lookup tables for the clock-divider configuration master.
// Optional build macro used by cd_cfg_master: CD_CFG_AUTO_APPLY_EN.
package cd_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_VGA  = 3'd1,
        ST_WR_UART = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } cfg_state_e;

    localparam logic [7:0] DEF_ADDR_VGA  = 8'h01;
    localparam logic [7:0] DEF_ADDR_UART = 8'h02;

    // VGA pixel-clock divider limit per resolution select.
    function automatic logic [15:0] res_limit(input logic [1:0] idx);
        case (idx)
            2'd0:    res_limit = 16'd1;
            2'd1:    res_limit = 16'd0;
            2'd2:    res_limit = 16'd3;
            2'd3:    res_limit = 16'd7;
            default: res_limit = 16'd1;
        endcase
    endfunction

    // UART 16x oversampling divider limit at 100 MHz: 9600/19200/57600/115200 baud.
    function automatic logic [15:0] baud_limit(input logic [1:0] idx);
        case (idx)
            2'd0:    baud_limit = 16'd650;
            2'd1:    baud_limit = 16'd325;
            2'd2:    baud_limit = 16'd108;
            2'd3:    baud_limit = 16'd53;
            default: baud_limit = 16'd650;
        endcase
    endfunction

    function automatic logic is_write_state(input cfg_state_e s);
        is_write_state = (s == ST_WR_VGA) || (s == ST_WR_UART);
    endfunction

    function automatic logic is_busy_state(input cfg_state_e s);
        is_busy_state = (s == ST_WR_VGA) || (s == ST_WR_UART) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/cd_cfg_timeout.sv
// Write-acceptance wait counter; o_expired flags the last allowed stall cycle.
module cd_cfg_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Saturating stall counter, restarted on every write-state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = i_count_en && (r_count == LAST);

endmodule

// File: rtl/cd_cfg_master.sv
// Issues the VGA then UART divider-limit writes after reset and on every apply.
// Build macro CD_CFG_AUTO_APPLY_EN: a select change seen while idle also relaunches.
module cd_cfg_master
    import cd_cfg_pkg::*;
#(
    parameter int unsigned WIDTH_CONFIG_ADDR = 8,
    parameter int unsigned WIDTH_CONFIG_DATA = 16,
    parameter logic [WIDTH_CONFIG_ADDR-1:0] ADDR_VGA  = WIDTH_CONFIG_ADDR'(DEF_ADDR_VGA),
    parameter logic [WIDTH_CONFIG_ADDR-1:0] ADDR_UART = WIDTH_CONFIG_ADDR'(DEF_ADDR_UART),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   sel_res,
    input  logic [1:0]                   sel_baud,
    input  logic                         apply,
    output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    output logic [WIDTH_CONFIG_DATA-1:0] c_data,
    output logic                         c_valid,
    input  logic                         c_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    cfg_state_e r_state;
    cfg_state_e w_state_next;

    logic       r_pending;
    logic       w_pending_next;
    logic       r_armed;
    logic [1:0] r_res_q;
    logic [1:0] r_baud_q;
    logic [1:0] w_res_next;
    logic [1:0] w_baud_next;
    logic       w_err_next;
    logic       w_launch;
    logic       w_sel_changed;
    logic       w_tmo_clear;
    logic       w_tmo_count_en;
    logic       w_tmo_expired;

    logic [WIDTH_CONFIG_ADDR-1:0] r_c_addr;
    logic [WIDTH_CONFIG_DATA-1:0] r_c_data;
    logic                         r_c_valid;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_err;

`ifdef CD_CFG_AUTO_APPLY_EN
    assign w_sel_changed = ((r_state == ST_IDLE) || (r_state == ST_ERR)) &&
                           ({sel_res, sel_baud} != {r_res_q, r_baud_q});
`else
    assign w_sel_changed = 1'b0;
`endif

    assign w_pending_next = apply | w_sel_changed | (r_pending & ~w_launch);
    assign w_tmo_clear    = (w_state_next != r_state);
    assign w_tmo_count_en = is_write_state(r_state) && !c_ready;

    cd_cfg_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_tmo_clear),
        .i_count_en (w_tmo_count_en),
        .o_expired  (w_tmo_expired)
    );

    // Next-state, latched selects and error flag.
    always_comb begin
        w_state_next = r_state;
        w_res_next   = r_res_q;
        w_baud_next  = r_baud_q;
        w_err_next   = r_err;
        w_launch     = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (r_pending && r_armed) begin
                    w_launch     = 1'b1;
                    w_res_next   = sel_res;
                    w_baud_next  = sel_baud;
                    w_err_next   = 1'b0;
                    w_state_next = ST_WR_VGA;
                end else begin
                    w_state_next = r_state;
                end
            end
            ST_WR_VGA: begin
                if (c_ready) begin
                    w_state_next = ST_WR_UART;
                end else if (w_tmo_expired) begin
                    w_state_next = ST_ERR;
                    w_err_next   = 1'b1;
                end else begin
                    w_state_next = ST_WR_VGA;
                end
            end
            ST_WR_UART: begin
                if (c_ready) begin
                    w_state_next = ST_DONE;
                end else if (w_tmo_expired) begin
                    w_state_next = ST_ERR;
                    w_err_next   = 1'b1;
                end else begin
                    w_state_next = ST_WR_UART;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, pending flag and latched selects; r_armed gives one settle cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b1;
            r_armed   <= 1'b0;
            r_res_q   <= 2'd0;
            r_baud_q  <= 2'd0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_armed   <= 1'b1;
            r_res_q   <= w_res_next;
            r_baud_q  <= w_baud_next;
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_c_addr  <= '0;
            r_c_data  <= '0;
        end else begin
            r_c_valid <= is_write_state(w_state_next);
            r_busy    <= is_busy_state(w_state_next);
            r_done    <= (w_state_next == ST_DONE);
            r_err     <= w_err_next;
            if (w_state_next == ST_WR_VGA) begin
                r_c_addr <= ADDR_VGA;
                r_c_data <= WIDTH_CONFIG_DATA'(res_limit(w_res_next));
            end else if (w_state_next == ST_WR_UART) begin
                r_c_addr <= ADDR_UART;
                r_c_data <= WIDTH_CONFIG_DATA'(baud_limit(w_baud_next));
            end else begin
                r_c_addr <= r_c_addr;
                r_c_data <= r_c_data;
            end
        end
    end

    assign c_addr  = r_c_addr;
    assign c_data  = r_c_data;
    assign c_valid = r_c_valid;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_cd_cfg_master.sv
// Directed bench for cd_cfg_master: vector table plus hand-written corner sequences.
module tb_cd_cfg_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel_res;
    logic [1:0]  sel_baud;
    logic        apply;
    logic [7:0]  c_addr;
    logic [15:0] c_data;
    logic        c_valid;
    logic        c_ready;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  res;
        logic [1:0]  baud;
        logic [15:0] vga;
        logic [15:0] uart;
    } vec_t;

    vec_t vecs [5];

    cd_cfg_master #(
        .WIDTH_CONFIG_ADDR (8),
        .WIDTH_CONFIG_DATA (16),
        .ADDR_VGA          (8'h01),
        .ADDR_UART         (8'h02),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_res  (sel_res),
        .sel_baud (sel_baud),
        .apply    (apply),
        .c_addr   (c_addr),
        .c_data   (c_data),
        .c_valid  (c_valid),
        .c_ready  (c_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // apply sampled at edge N; writes after N+1 and N+2, done after N+3, idle after N+4.
    task automatic run_seq(input string tag, input logic [1:0] res, input logic [1:0] baud,
                           input logic [15:0] exp_vga, input logic [15:0] exp_uart,
                           input logic err_before);
        sel_res  = res;
        sel_baud = baud;
        apply    = 1'b1;
        tick();
        apply = 1'b0;
        check({tag, "_n_valid"}, 32'(c_valid), 32'd0);
        check({tag, "_n_err"},   32'(err),     32'(err_before));
        tick();
        check({tag, "_vga_valid"}, 32'(c_valid), 32'd1);
        check({tag, "_vga_addr"},  32'(c_addr),  32'h01);
        check({tag, "_vga_data"},  32'(c_data),  32'(exp_vga));
        check({tag, "_vga_busy"},  32'(busy),    32'd1);
        check({tag, "_vga_err"},   32'(err),     32'd0);
        tick();
        check({tag, "_uart_valid"}, 32'(c_valid), 32'd1);
        check({tag, "_uart_addr"},  32'(c_addr),  32'h02);
        check({tag, "_uart_data"},  32'(c_data),  32'(exp_uart));
        tick();
        check({tag, "_done"},       32'(done),    32'd1);
        check({tag, "_done_valid"}, 32'(c_valid), 32'd0);
        check({tag, "_done_busy"},  32'(busy),    32'd1);
        tick();
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int valid_cnt;
        int stall;
        int acc_v;
        int acc_u;
        int unstable;
        int high_cnt;
        int err_early;
        logic in_write;
        logic got_done;
        logic [7:0]  hold_addr;
        logic [15:0] hold_data;
        logic [15:0] acc_v_data;
        logic [15:0] acc_u_data;

        vecs[0] = '{res: 2'd0, baud: 2'd0, vga: 16'd1, uart: 16'd650};
        vecs[1] = '{res: 2'd1, baud: 2'd1, vga: 16'd0, uart: 16'd325};
        vecs[2] = '{res: 2'd2, baud: 2'd2, vga: 16'd3, uart: 16'd108};
        vecs[3] = '{res: 2'd3, baud: 2'd3, vga: 16'd7, uart: 16'd53};
        vecs[4] = '{res: 2'd3, baud: 2'd0, vga: 16'd7, uart: 16'd650};

        rst_n    = 1'b0;
        sel_res  = 2'd2;
        sel_baud = 2'd3;
        apply    = 1'b0;
        c_ready  = 1'b1;

        // Reset values.
        #12;
        check("rst_valid", 32'(c_valid), 32'd0);
        check("rst_busy",  32'(busy),    32'd0);
        check("rst_done",  32'(done),    32'd0);
        check("rst_err",   32'(err),     32'd0);
        check("rst_addr",  32'(c_addr),  32'd0);
        check("rst_data",  32'(c_data),  32'd0);

        // Boot sequence: first c_valid after the 2nd edge following release.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("boot_e1_valid", 32'(c_valid), 32'd0);
        tick();
        check("boot_vga_valid", 32'(c_valid), 32'd1);
        check("boot_vga_addr",  32'(c_addr),  32'h01);
        check("boot_vga_data",  32'(c_data),  32'h0003);
        tick();
        check("boot_uart_valid", 32'(c_valid), 32'd1);
        check("boot_uart_addr",  32'(c_addr),  32'h02);
        check("boot_uart_data",  32'(c_data),  32'h0035);
        tick();
        check("boot_done", 32'(done), 32'd1);
        tick();
        check("boot_idle_busy", 32'(busy), 32'd0);
        check("boot_idle_done", 32'(done), 32'd0);
        tick();

        // Table-driven apply sequences with c_ready held high.
        for (int i = 0; i < 5; i++) begin
            run_seq($sformatf("vec%0d", i), vecs[i].res, vecs[i].baud, vecs[i].vga, vecs[i].uart, 1'b0);
        end

        // Each write stalled 5 cycles before acceptance.
        sel_res  = 2'd1;
        sel_baud = 2'd0;
        c_ready  = 1'b0;
        apply    = 1'b1;
        tick();
        apply     = 1'b0;
        stall     = 0;
        acc_v     = 0;
        acc_u     = 0;
        unstable  = 0;
        valid_cnt = 0;
        in_write  = 1'b0;
        got_done  = 1'b0;
        hold_addr = 8'h00;
        hold_data = 16'h0000;
        acc_v_data = 16'hffff;
        acc_u_data = 16'hffff;
        for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
            tick();
            if (done) got_done = 1'b1;
            if (c_valid) begin
                valid_cnt++;
                if (!in_write) begin
                    in_write  = 1'b1;
                    hold_addr = c_addr;
                    hold_data = c_data;
                end else if ((c_addr !== hold_addr) || (c_data !== hold_data)) begin
                    unstable++;
                end
                if (stall >= 5) begin
                    c_ready  = 1'b1;
                    in_write = 1'b0;
                    stall    = 0;
                    if (c_addr == 8'h01) begin
                        acc_v++;
                        acc_v_data = c_data;
                    end else if (c_addr == 8'h02) begin
                        acc_u++;
                        acc_u_data = c_data;
                    end
                end else begin
                    c_ready = 1'b0;
                    stall++;
                end
            end else begin
                c_ready = 1'b0;
            end
        end
        c_ready = 1'b1;
        check("stall_done",       32'(got_done),   32'd1);
        check("stall_vga_accept", 32'(acc_v),      32'd1);
        check("stall_uart_accept",32'(acc_u),      32'd1);
        check("stall_vga_data",   32'(acc_v_data), 32'd0);
        check("stall_uart_data",  32'(acc_u_data), 32'd650);
        check("stall_unstable",   32'(unstable),   32'd0);
        check("stall_valid_cyc",  32'(valid_cnt),  32'd12);
        tick();
        check("stall_idle_busy", 32'(busy), 32'd0);

        // Timeout: c_ready stuck low for TIMEOUT_CYCLES = 16.
        sel_res  = 2'd3;
        sel_baud = 2'd1;
        c_ready  = 1'b0;
        apply    = 1'b1;
        tick();
        apply     = 1'b0;
        high_cnt  = 0;
        err_early = 0;
        tick();
        while (c_valid && high_cnt < 40) begin
            high_cnt++;
            if (err) err_early++;
            if (c_addr !== 8'h01) unstable++;
            tick();
        end
        check("tmo_high_cycles", 32'(high_cnt),  32'd16);
        check("tmo_err_early",   32'(err_early), 32'd0);
        check("tmo_err",         32'(err),       32'd1);
        check("tmo_valid",       32'(c_valid),   32'd0);
        check("tmo_busy",        32'(busy),      32'd0);
        check("tmo_addr_stable", 32'(unstable),  32'd0);
        tick();
        tick();
        check("tmo_err_sticky", 32'(err), 32'd1);
        c_ready = 1'b1;
        run_seq("tmo_recover", 2'd3, 2'd1, 16'd7, 16'd325, 1'b1);

        // apply during WR_UART: current run completes, then one rerun with relaunch selects.
        sel_res  = 2'd0;
        sel_baud = 2'd1;
        apply    = 1'b1;
        tick();
        apply = 1'b0;
        tick();
        check("mid_vga_data", 32'(c_data), 32'd1);
        sel_res  = 2'd3;
        sel_baud = 2'd2;
        tick();
        check("mid_uart_data", 32'(c_data), 32'd325);
        check("mid_uart_addr", 32'(c_addr), 32'h02);
        apply = 1'b1;
        tick();
        apply = 1'b0;
        check("mid_done", 32'(done), 32'd1);
        tick();
        check("mid_idle_busy", 32'(busy), 32'd0);
        tick();
        check("mid_re_valid", 32'(c_valid), 32'd1);
        check("mid_re_vga",   32'(c_data),  32'd7);
        tick();
        check("mid_re_uart",  32'(c_data),  32'd108);
        tick();
        check("mid_re_done",  32'(done),    32'd1);
        tick();
        check("mid_re_idle",  32'(busy),    32'd0);
        tick();
        check("mid_no_third", 32'(c_valid), 32'd0);

        // apply coincident with done: relaunch from IDLE one cycle later.
        sel_res  = 2'd0;
        sel_baud = 2'd0;
        apply    = 1'b1;
        tick();
        apply = 1'b0;
        tick();
        tick();
        tick();
        check("coin_done", 32'(done), 32'd1);
        apply = 1'b1;
        tick();
        apply = 1'b0;
        check("coin_idle_valid", 32'(c_valid), 32'd0);
        check("coin_idle_busy",  32'(busy),    32'd0);
        tick();
        check("coin_re_valid", 32'(c_valid), 32'd1);
        check("coin_re_vga",   32'(c_data),  32'd1);
        tick();
        check("coin_re_uart",  32'(c_data),  32'd650);
        tick();
        check("coin_re_done",  32'(done),    32'd1);
        tick();

        // sel_baud 0 -> 1 while idle, no apply.
        sel_baud = 2'd1;
        tick();
`ifdef CD_CFG_AUTO_APPLY_EN
        tick();
        check("auto_vga_valid", 32'(c_valid), 32'd1);
        check("auto_vga_data",  32'(c_data),  32'd1);
        tick();
        check("auto_uart_addr", 32'(c_addr),  32'h02);
        check("auto_uart_data", 32'(c_data),  32'd325);
        tick();
        check("auto_done",      32'(done),    32'd1);
        tick();
`else
        high_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (c_valid) high_cnt++;
        end
        check("noauto_no_write", 32'(high_cnt), 32'd0);
        check("noauto_busy",     32'(busy),     32'd0);
`endif

        // Reset asserted during WR_VGA: c_valid drops at once, boot reruns.
        sel_res  = 2'd1;
        sel_baud = 2'd2;
        apply    = 1'b1;
        tick();
        apply = 1'b0;
        tick();
        check("rstmid_pre_valid", 32'(c_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 32'(c_valid), 32'd0);
        check("rstmid_busy",  32'(busy),    32'd0);
        #20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rstmid_e1_valid", 32'(c_valid), 32'd0);
        tick();
        check("rstmid_vga_valid", 32'(c_valid), 32'd1);
        check("rstmid_vga_data",  32'(c_data),  32'd0);
        tick();
        check("rstmid_uart_addr", 32'(c_addr),  32'h02);
        check("rstmid_uart_data", 32'(c_data),  32'd108);
        tick();
        check("rstmid_done",      32'(done),    32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
